// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: FSM encodings and wait-counter width.
package mem_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/mem_responder_if.sv
// Request/acknowledge bus between the control unit (master) and the memory responder (slave).
interface mem_responder_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
);
   logic                  req;
   logic                  we;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  ack;
   logic                  busy;

   modport master (
      output req, we, addr, wdata,
      input  rdata, ack, busy
   );

   modport slave (
      input  req, we, addr, wdata,
      output rdata, ack, busy
   );
endinterface

// File: rtl/mem_responder_ram_array.sv
// Word-addressed RAM with synchronous write and registered read.
// The storage itself is never reset; only the read register is, so rdata starts at 0.
module ram_array #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_we_s,
   input  logic                  i_re_s,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] r_rdata;

   // Write port: commit data on the write strobe.
   always_ff @(posedge clk) begin
      if (i_we_s) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   // Read register: updated only on the read strobe, holds otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdata <= '0;
      end else if (i_re_s) begin
         r_rdata <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts one request at a time, waits WAIT_STATES cycles,
// performs the RAM access and answers with a four-phase req/ack handshake.
//
//  state   | meaning
//  --------+---------------------------------------------------------
//  IDLE    | waiting for req; request fields latched on acceptance
//  WAIT    | counting down wait states; access happens when count is 0
//  ACK     | ack held high until req is seen low
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 4,
   parameter int WAIT_STATES = 1
) (
   input  logic            clk,
   input  logic            rst,
   mem_responder_if.slave  bus
);

   state_t                r_state;
   logic [WAIT_CNT_W-1:0] r_cnt;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_ack;
   logic                  r_busy;

   logic                  w_access;
   logic                  w_we_s;
   logic                  w_re_s;
   logic [DATA_WIDTH-1:0] w_rdata;

   // The access edge is the last WAIT cycle; strobes come straight from registered state.
   assign w_access = (r_state == ST_WAIT) && (r_cnt == '0);
   assign w_we_s   = w_access &&  r_we;
   assign w_re_s   = w_access && !r_we;

   // Handshake FSM with request latches, wait counter and registered ack/busy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_ack   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.req) begin
                  r_we    <= bus.we;
                  r_addr  <= bus.addr;
                  r_wdata <= bus.wdata;
                  r_cnt   <= WAIT_CNT_W'(WAIT_STATES);
                  r_busy  <= 1'b1;
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 1'b1;
               end else begin
                  r_ack   <= 1'b1;
                  r_state <= ST_ACK;
               end
            end
            ST_ACK: begin
               if (!bus.req) begin
                  r_ack   <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_ack   <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   ram_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .i_we_s  (w_we_s),
      .i_re_s  (w_re_s),
      .i_addr  (r_addr),
      .i_wdata (r_wdata),
      .o_rdata (w_rdata)
   );

   assign bus.ack   = r_ack;
   assign bus.busy  = r_busy;
   assign bus.rdata = w_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances with WAIT_STATES 1, 0 and 3
// share clock and reset; index 0 = ws1, 1 = ws0, 2 = ws3.
module tb_mem_responder;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   logic       req_v   [3];
   logic       we_v    [3];
   logic [3:0] addr_v  [3];
   logic [7:0] wdata_v [3];
   logic       ack_v   [3];
   logic       busy_v  [3];
   logic [7:0] rdata_v [3];

   int n_chk  = 0;
   int n_fail = 0;

   mem_responder_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if_ws1 ();
   mem_responder_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if_ws0 ();
   mem_responder_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if_ws3 ();

   assign if_ws1.req   = req_v[0];
   assign if_ws1.we    = we_v[0];
   assign if_ws1.addr  = addr_v[0];
   assign if_ws1.wdata = wdata_v[0];
   assign ack_v[0]     = if_ws1.ack;
   assign busy_v[0]    = if_ws1.busy;
   assign rdata_v[0]   = if_ws1.rdata;

   assign if_ws0.req   = req_v[1];
   assign if_ws0.we    = we_v[1];
   assign if_ws0.addr  = addr_v[1];
   assign if_ws0.wdata = wdata_v[1];
   assign ack_v[1]     = if_ws0.ack;
   assign busy_v[1]    = if_ws0.busy;
   assign rdata_v[1]   = if_ws0.rdata;

   assign if_ws3.req   = req_v[2];
   assign if_ws3.we    = we_v[2];
   assign if_ws3.addr  = addr_v[2];
   assign if_ws3.wdata = wdata_v[2];
   assign ack_v[2]     = if_ws3.ack;
   assign busy_v[2]    = if_ws3.busy;
   assign rdata_v[2]   = if_ws3.rdata;

   mem_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .WAIT_STATES(1)) u_dut_ws1 (
      .clk (clk), .rst (rst), .bus (if_ws1)
   );
   mem_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .WAIT_STATES(0)) u_dut_ws0 (
      .clk (clk), .rst (rst), .bus (if_ws0)
   );
   mem_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .WAIT_STATES(3)) u_dut_ws3 (
      .clk (clk), .rst (rst), .bus (if_ws3)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_req(input int d, input logic we, input logic [3:0] a, input logic [7:0] wd);
      req_v[d]   = 1'b1;
      we_v[d]    = we;
      addr_v[d]  = a;
      wdata_v[d] = wd;
   endtask

   task automatic wait_ack(input int d, output int n);
      n = 0;
      while (ack_v[d] !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
   endtask

   task automatic finish_req(input int d);
      int n;
      req_v[d] = 1'b0;
      n = 0;
      while (ack_v[d] !== 1'b0 && n < 40) begin
         tick();
         n++;
      end
      chk($sformatf("ack_release[%0d]", d), {31'd0, ack_v[d]}, 32'd0);
      chk($sformatf("busy_release[%0d]", d), {31'd0, busy_v[d]}, 32'd0);
   endtask

   task automatic do_write(input int d, input logic [3:0] a, input logic [7:0] wd, input int ws);
      int n;
      start_req(d, 1'b1, a, wd);
      wait_ack(d, n);
      chk($sformatf("wr_latency[%0d] a=%0h", d, a), n, ws + 2);
      finish_req(d);
   endtask

   task automatic do_read(input int d, input logic [3:0] a, input logic [7:0] exp, input int ws);
      int n;
      start_req(d, 1'b0, a, 8'h00);
      wait_ack(d, n);
      chk($sformatf("rd_latency[%0d] a=%0h", d, a), n, ws + 2);
      chk($sformatf("rd_data[%0d] a=%0h", d, a), {24'd0, rdata_v[d]}, {24'd0, exp});
      finish_req(d);
   endtask

   initial begin
      int  n;
      bit  seen_ack;

      for (int d = 0; d < 3; d++) begin
         req_v[d] = 1'b0; we_v[d] = 1'b0; addr_v[d] = 4'h0; wdata_v[d] = 8'h00;
      end
      rst = 1'b1;
      #3;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("reset_ack[%0d]", d),   {31'd0, ack_v[d]},   32'd0);
         chk($sformatf("reset_busy[%0d]", d),  {31'd0, busy_v[d]},  32'd0);
         chk($sformatf("reset_rdata[%0d]", d), {24'd0, rdata_v[d]}, 32'd0);
      end
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Write then read back, one wait state
      do_write(0, 4'h3, 8'hA5, 1);
      do_read(0, 4'h3, 8'hA5, 1);
      do_write(0, 4'h4, 8'h66, 1);
      chk("rdata_hold_after_write", {24'd0, rdata_v[0]}, 32'h0000_00A5);
      tick(); tick();
      chk("rdata_hold_idle", {24'd0, rdata_v[0]}, 32'h0000_00A5);

      // Address/data change after acceptance is ignored
      do_write(0, 4'h2, 8'h77, 1);
      start_req(0, 1'b1, 4'h1, 8'h11);
      tick();
      addr_v[0]  = 4'h2;
      wdata_v[0] = 8'h22;
      wait_ack(0, n);
      chk("addr_change_latency", n, 2);
      finish_req(0);
      do_read(0, 4'h1, 8'h11, 1);
      do_read(0, 4'h2, 8'h77, 1);

      // req dropped during WAIT: one-cycle ack, write still committed at max address
      start_req(0, 1'b1, 4'hF, 8'h5A);
      tick();
      req_v[0] = 1'b0;
      tick();
      chk("early_drop_wait_ack", {31'd0, ack_v[0]}, 32'd0);
      chk("early_drop_wait_busy", {31'd0, busy_v[0]}, 32'd1);
      tick();
      chk("early_drop_ack_pulse", {31'd0, ack_v[0]}, 32'd1);
      tick();
      chk("early_drop_ack_gone", {31'd0, ack_v[0]}, 32'd0);
      chk("early_drop_busy_gone", {31'd0, busy_v[0]}, 32'd0);
      do_read(0, 4'hF, 8'h5A, 1);

      // Zero wait states; ack and busy hold while req stays high
      start_req(1, 1'b1, 4'h9, 8'hC3);
      wait_ack(1, n);
      chk("ws0_latency", n, 2);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("ws0_ack_hold%0d", i),  {31'd0, ack_v[1]},  32'd1);
         chk($sformatf("ws0_busy_hold%0d", i), {31'd0, busy_v[1]}, 32'd1);
      end
      finish_req(1);
      do_read(1, 4'h9, 8'hC3, 0);

      // Reset in the middle of WAIT aborts the write; reset outputs are immediate
      do_write(2, 4'h0, 8'h3C, 3);
      start_req(2, 1'b1, 4'h0, 8'hFF);
      tick();
      tick();
      chk("ws3_busy_in_wait", {31'd0, busy_v[2]}, 32'd1);
      chk("ws3_ack_in_wait",  {31'd0, ack_v[2]},  32'd0);
      #2;
      rst = 1'b1;
      #1;
      chk("midcycle_rst_busy",     {31'd0, busy_v[2]},  32'd0);
      chk("midcycle_rst_ack",      {31'd0, ack_v[2]},   32'd0);
      chk("midcycle_rst_rdata_ws1", {24'd0, rdata_v[0]}, 32'd0);
      chk("midcycle_rst_rdata_ws0", {24'd0, rdata_v[1]}, 32'd0);
      req_v[2] = 1'b0;
      tick();
      rst = 1'b0;
      seen_ack = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (ack_v[2] !== 1'b0) seen_ack = 1'b1;
      end
      chk("aborted_no_ack", {31'd0, seen_ack}, 32'd0);
      do_read(2, 4'h0, 8'h3C, 3);
      do_read(0, 4'hF, 8'h5A, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
